tds_frame_tx: RTL and testbench

TDS_FRAME_TX -- requirements
Module: tds_frame_tx

---
 rtl/tds_frame_tx_if.sv | 8 +
 rtl/tds_frame_tx.sv | 98 +++++++++
 tb/tb_tds_frame_tx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tds_frame_tx_if.sv
// tds_frame_tx_if: upstream payload valid/ready handshake feeding the frame transmitter.
interface tds_frame_tx_if;
    logic [19:0] payload_in;
    logic        payload_valid;
    logic        payload_ready;
    modport master(output payload_in, payload_valid, input payload_ready);
    modport slave(input payload_in, payload_valid, output payload_ready);
endinterface

// File: rtl/tds_frame_tx.sv
// tds_frame_tx: frames upstream payload as HEADER/PAYLOAD/TRAILER/GAP words for the GT transmitter.
// Optional TDS_TX_PRBS_EN adds an internal PRBS-7 payload source selected by prbs_sel.
module tds_frame_tx #(
    parameter int          PAYLOAD_WORDS = 8,
    parameter int          GAP_WORDS     = 2,
    parameter logic [19:0] IDLE_WORD     = 20'hBC3C5,
    parameter logic [19:0] FILL_WORD     = 20'h3C5BC
) (
    input  logic          data_clk,
    input  logic          gt0_tx_system_reset_c,
    input  logic          tx_enable,
    input  logic          prbs_sel,
    tds_frame_tx_if.slave pl,
    output logic [19:0]   GTP_data_in,
    output logic          frame_active,
    output logic [15:0]   frame_count,
    output logic [15:0]   underflow_count
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TRAILER, GAP} state_t;
    state_t      state, state_nx;
    logic [7:0]  word_cnt;
    logic [3:0]  gap_cnt;
    logic [15:0] xor16;
    logic [19:0] data_word;
    logic        prbs_mode, start_src, xfer, last;
`ifdef TDS_TX_PRBS_EN
    logic [6:0]  prbs, prbs_nx;
    logic [19:0] prbs_word;
    // Twenty PRBS-7 steps per cycle; the first generated bit lands in the MSB.
    always_comb begin
        prbs_nx   = prbs;
        prbs_word = '0;
        for (int i = 19; i >= 0; i--) begin
            prbs_word[i] = prbs_nx[6] ^ prbs_nx[5];
            prbs_nx      = {prbs_nx[5:0], prbs_word[i]};
        end
    end
    always_ff @(posedge data_clk or posedge gt0_tx_system_reset_c)
        if (gt0_tx_system_reset_c) begin
            prbs      <= 7'h7F;
            prbs_mode <= 1'b0;
        end else begin
            if (state == IDLE && state_nx == HEADER) prbs_mode <= prbs_sel;
            if (state == PAYLOAD && prbs_mode) prbs <= prbs_nx;
        end
    assign start_src = pl.payload_valid | prbs_sel;
    assign data_word = prbs_mode ? prbs_word : pl.payload_in;
`else
    logic unused_prbs_sel;
    assign unused_prbs_sel = prbs_sel;
    assign prbs_mode       = 1'b0;
    assign start_src       = pl.payload_valid;
    assign data_word       = pl.payload_in;
`endif
    assign pl.payload_ready = state == PAYLOAD && !prbs_mode;
    assign xfer             = state == PAYLOAD && (prbs_mode || pl.payload_valid);
    assign last             = xfer && word_cnt == 8'(PAYLOAD_WORDS - 1);
    assign frame_active     = state inside {HEADER, PAYLOAD, TRAILER};
    always_ff @(posedge data_clk or posedge gt0_tx_system_reset_c)
        if (gt0_tx_system_reset_c) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = tx_enable && start_src ? HEADER : IDLE;
            HEADER:  state_nx = PAYLOAD;
            PAYLOAD: state_nx = last ? TRAILER : PAYLOAD;
            TRAILER: state_nx = GAP;
            GAP:     state_nx = gap_cnt == 4'(GAP_WORDS - 1) ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge data_clk or posedge gt0_tx_system_reset_c)
        if (gt0_tx_system_reset_c) begin
            GTP_data_in     <= IDLE_WORD;
            word_cnt        <= '0;
            gap_cnt         <= '0;
            xor16           <= '0;
            frame_count     <= '0;
            underflow_count <= '0;
        end else begin
            GTP_data_in <= state == HEADER  ? {4'hA, frame_count} :
                           state == PAYLOAD ? (xfer ? data_word : FILL_WORD) :
                           state == TRAILER ? {4'h5, xor16} : IDLE_WORD;
            if (state == HEADER) begin
                word_cnt <= '0;
                xor16    <= '0;
            end
            if (xfer) begin
                word_cnt <= word_cnt + 8'd1;
                xor16    <= xor16 ^ data_word[15:0];
            end
            if (state == PAYLOAD && !xfer && underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'd1;
            if (state == TRAILER) frame_count <= frame_count + 16'd1;
            gap_cnt <= state == GAP ? gap_cnt + 4'd1 : 4'd0;
        end
endmodule

// File: tb/tb_tds_frame_tx.sv
// tb_tds_frame_tx: directed checks of framing, underflow fill, counter wrap, reset abort and PRBS payload.
module tb_tds_frame_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_enable = 1'b0;
    logic        prbs_sel = 1'b0;
    logic [19:0] gtp;
    logic        active;
    logic [15:0] fc, uf;
    logic [19:0] obs[$];
    int          total = 0;
    int          bad = 0;
    tds_frame_tx_if pl();
    tds_frame_tx dut (
        .data_clk(clk),
        .gt0_tx_system_reset_c(rst),
        .tx_enable(tx_enable),
        .prbs_sel(prbs_sel),
        .pl(pl),
        .GTP_data_in(gtp),
        .frame_active(active),
        .frame_count(fc),
        .underflow_count(uf)
    );
    always #5 clk = ~clk;
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tx_enable = 1'b0;
        pl.payload_valid = 1'b0;
        pl.payload_in = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask
    // Feeds words 1..8 per frame, optionally withholding valid for drop_len payload cycles before word drop_at.
    task automatic drive(input int n, input int drop_at, input int drop_len, input bit hold_en);
        int nxt = 1;
        int dropped = 0;
        bit rdy, drop;
        obs.delete();
        for (int c = 0; c < n; c++) begin
            rdy = pl.payload_ready;
            drop = rdy && nxt == drop_at && dropped < drop_len;
            pl.payload_valid = !drop;
            pl.payload_in = 20'(nxt);
            tx_enable = hold_en || c == 0;
            @(posedge clk);
            if (drop) dropped++;
            else if (rdy) nxt = nxt == 8 ? 1 : nxt + 1;
            @(negedge clk);
            obs.push_back(gtp);
        end
        tx_enable = 1'b0;
    endtask
    task automatic test_reset();
        @(negedge clk);
        pl.payload_valid = 1'b1;
        rst = 1'b1;
        #1;
        total += 5;
        if (gtp !== 20'hBC3C5) begin bad++; $display("FAIL reset_word got %h want bc3c5", gtp); end
        if (pl.payload_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", pl.payload_ready); end
        if (active !== 1'b0) begin bad++; $display("FAIL reset_active got %b want 0", active); end
        if (fc !== 16'h0) begin bad++; $display("FAIL reset_fc got %h want 0", fc); end
        if (uf !== 16'h0) begin bad++; $display("FAIL reset_uf got %h want 0", uf); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if (gtp !== 20'hBC3C5 || fc !== 16'h0 || active !== 1'b0) begin
                bad++;
                $display("FAIL idle_hold cycle %0d got %h fc %h act %b want bc3c5 fc 0 act 0", c, gtp, fc, active);
            end
        end
        pl.payload_valid = 1'b0;
    endtask
    task automatic test_basic();
        logic [19:0] exp[13] = '{20'hBC3C5, 20'hA0000, 20'h00001, 20'h00002, 20'h00003, 20'h00004, 20'h00005,
                                 20'h00006, 20'h00007, 20'h00008, 20'h50008, 20'hBC3C5, 20'hBC3C5};
        do_reset();
        drive(13, 0, 0, 1'b1);
        tx_enable = 1'b1;
        for (int i = 0; i < 13; i++) begin
            total++;
            if (obs[i] !== exp[i]) begin bad++; $display("FAIL basic word %0d got %h want %h", i, obs[i], exp[i]); end
        end
        total += 2;
        if (fc !== 16'd1) begin bad++; $display("FAIL basic_fc got %0d want 1", fc); end
        if (uf !== 16'd0) begin bad++; $display("FAIL basic_uf got %0d want 0", uf); end
    endtask
    task automatic test_back_to_back();
        logic [19:0] exp[13] = '{20'hBC3C5, 20'hA0001, 20'h00001, 20'h00002, 20'h00003, 20'h00004, 20'h00005,
                                 20'h00006, 20'h00007, 20'h00008, 20'h50008, 20'hBC3C5, 20'hBC3C5};
        drive(13, 0, 0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            total++;
            if (obs[i] !== exp[i]) begin bad++; $display("FAIL b2b word %0d got %h want %h", i, obs[i], exp[i]); end
        end
        total++;
        if (fc !== 16'd2) begin bad++; $display("FAIL b2b_fc got %0d want 2", fc); end
    endtask
    task automatic test_underflow();
        logic [19:0] exp[16] = '{20'hBC3C5, 20'hA0000, 20'h00001, 20'h00002, 20'h00003, 20'h00004,
                                 20'h3C5BC, 20'h3C5BC, 20'h3C5BC, 20'h00005, 20'h00006, 20'h00007,
                                 20'h00008, 20'h50008, 20'hBC3C5, 20'hBC3C5};
        do_reset();
        drive(16, 5, 3, 1'b0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs[i] !== exp[i]) begin bad++; $display("FAIL underflow word %0d got %h want %h", i, obs[i], exp[i]); end
        end
        total += 2;
        if (uf !== 16'd3) begin bad++; $display("FAIL underflow_count got %0d want 3", uf); end
        if (fc !== 16'd1) begin bad++; $display("FAIL underflow_fc got %0d want 1", fc); end
        repeat (5) @(negedge clk);
        total++;
        if (gtp !== 20'hBC3C5 || active !== 1'b0) begin
            bad++;
            $display("FAIL no_restart got %h act %b want bc3c5 act 0", gtp, active);
        end
    endtask
    task automatic test_reset_mid();
        drive(6, 0, 0, 1'b0);
        total++;
        if (obs[5] !== 20'h00004) begin bad++; $display("FAIL mid_pre got %h want 00004", obs[5]); end
        rst = 1'b1;
        @(negedge clk);
        total += 5;
        if (gtp !== 20'hBC3C5) begin bad++; $display("FAIL mid_word got %h want bc3c5", gtp); end
        if (fc !== 16'd0) begin bad++; $display("FAIL mid_fc got %0d want 0", fc); end
        if (uf !== 16'd0) begin bad++; $display("FAIL mid_uf got %0d want 0", uf); end
        if (active !== 1'b0) begin bad++; $display("FAIL mid_active got %b want 0", active); end
        if (pl.payload_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got %b want 0", pl.payload_ready); end
        rst = 1'b0;
        drive(2, 0, 0, 1'b0);
        total++;
        if (obs[1] !== 20'hA0000) begin bad++; $display("FAIL mid_header got %h want a0000", obs[1]); end
    endtask
    task automatic test_wrap();
        logic [19:0] exp[13] = '{20'hBC3C5, 20'hAFFFF, 20'h00001, 20'h00002, 20'h00003, 20'h00004, 20'h00005,
                                 20'h00006, 20'h00007, 20'h00008, 20'h50008, 20'hBC3C5, 20'hBC3C5};
        do_reset();
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        drive(13, 0, 0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            total++;
            if (obs[i] !== exp[i]) begin bad++; $display("FAIL wrap word %0d got %h want %h", i, obs[i], exp[i]); end
        end
        total++;
        if (fc !== 16'd0) begin bad++; $display("FAIL wrap_fc got %h want 0000", fc); end
    endtask
`ifdef TDS_TX_PRBS_EN
    task automatic test_prbs();
        bit b[$];
        logic [19:0] w[8];
        logic [15:0] x = '0;
        int rdy_hi = 0;
        for (int i = 0; i < 7; i++) b.push_back(1'b1);
        while (b.size() < 7 + 160) b.push_back(b[b.size() - 7] ^ b[b.size() - 6]);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 20; j++) w[k][19 - j] = b[7 + 20 * k + j];
            x ^= w[k][15:0];
        end
        do_reset();
        prbs_sel = 1'b1;
        obs.delete();
        for (int c = 0; c < 13; c++) begin
            tx_enable = c == 0;
            pl.payload_valid = 1'b0;
            if (pl.payload_ready !== 1'b0) rdy_hi++;
            @(posedge clk);
            @(negedge clk);
            obs.push_back(gtp);
        end
        prbs_sel = 1'b0;
        total += 4;
        if (obs[1] !== 20'hA0000) begin bad++; $display("FAIL prbs_header got %h want a0000", obs[1]); end
        if (obs[10] !== {4'h5, x}) begin bad++; $display("FAIL prbs_trailer got %h want %h", obs[10], {4'h5, x}); end
        if (rdy_hi !== 0) begin bad++; $display("FAIL prbs_ready high cycles %0d want 0", rdy_hi); end
        if (uf !== 16'd0) begin bad++; $display("FAIL prbs_uf got %0d want 0", uf); end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (obs[2 + k] !== w[k]) begin bad++; $display("FAIL prbs word %0d got %h want %h", k, obs[2 + k], w[k]); end
        end
    endtask
`else
    task automatic test_prbs();
        do_reset();
        prbs_sel = 1'b1;
        tx_enable = 1'b1;
        repeat (6) @(negedge clk);
        total += 2;
        if (active !== 1'b0) begin bad++; $display("FAIL prbs_ignored active got %b want 0", active); end
        if (gtp !== 20'hBC3C5) begin bad++; $display("FAIL prbs_ignored word got %h want bc3c5", gtp); end
        prbs_sel = 1'b0;
        tx_enable = 1'b0;
    endtask
`endif
    initial begin
        pl.payload_valid = 1'b0;
        pl.payload_in = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        test_wrap();
        test_prbs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
